// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// signed mode handled as magnitude multiply plus a final conditional negate.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           state_dbg
);

  // Handshake: start is accepted only at a rising edge while busy=0; done is a
  // one-cycle pulse with result valid from then until the next done pulse.
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    sum;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude
  assign mag_a = (is_signed && opA[WIDTH-1]) ? ((~opA) + WIDTH'(1)) : opA;
  assign mag_b = (is_signed && opB[WIDTH-1]) ? ((~opB) + WIDTH'(1)) : opB;
  assign sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = neg_q ? ((~sum) + PW'(1)) : sum;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: an 8-bit instance for the named scenarios and a
// 4-bit instance swept over all operand pairs in both modes.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] res8;
  logic [1:0]  st8;

  logic        start4, sgn4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  res4;
  logic [1:0]  st4;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
    .opA(a8), .opB(b8), .busy(busy8), .done(done8), .result(res8),
    .state_dbg(st8)
  );

  seq_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sgn4),
    .opA(a4), .opB(b4), .busy(busy4), .done(done4), .result(res4),
    .state_dbg(st4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y, p;
    x = s ? {{28{a[3]}}, a} : {28'd0, a};
    y = s ? {{28{b[3]}}, b} : {28'd0, b};
    p = x * y;
    return p[7:0];
  endfunction

  // One full 8-bit operation: latency, busy length, result, and the done pulse width.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input string tag);
    int cyc, busy_n;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
    @(posedge clk);
    #1 start8 = 1'b0;
    cyc = 0; busy_n = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy8) busy_n++;
      if (done8) break;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_cycles"}, busy_n, 9);
    check({tag, "_result"}, res8, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, {done8, busy8}, 2'b00);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int cyc;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; sgn4 = s;
    @(posedge clk);
    #1 start4 = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done4) break;
    end
    check($sformatf("w4_lat_%0d_%0d_%0d", s, a, b), cyc, 5);
    check($sformatf("w4_res_%0d_%0d_%0d", s, a, b), res4, ref4(a, b, s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dones, first_done;
    logic [15:0] held;
    logic [7:0]  bb_a[3], bb_b[3];
    logic [15:0] bb_exp[3];

    rst_n = 1'b0;
    start8 = 0; sgn8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sgn4 = 0; a4 = 0; b4 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result8", res8, 16'h0);
    check("reset_flags8", {busy8, done8}, 2'b00);
    check("reset_state8", st8, 2'd0);
    check("reset_result4", res4, 8'h0);
    rst_n = 1'b1;

    // idle with start low: nothing happens
    repeat (3) @(negedge clk);
    check("idle_no_start", {busy8, done8, res8}, 18'h0);

    run8(8'd255, 8'd255, 1'b0, 16'hFE01, "u_255x255");
    run8(8'hFD,  8'd5,   1'b1, 16'hFFF1, "s_m3x5");
    run8(8'h80,  8'h80,  1'b1, 16'h4000, "s_m128xm128");
    run8(8'h80,  8'd1,   1'b1, 16'hFF80, "s_m128x1");
    run8(8'd127, 8'h80,  1'b1, 16'hC080, "s_127xm128");
    run8(8'hFF,  8'hFF,  1'b1, 16'h0001, "s_m1xm1");
    run8(8'd128, 8'd128, 1'b0, 16'h4000, "u_128x128");
    run8(8'd0,   8'd255, 1'b0, 16'h0000, "u_0x255");
    run8(8'd0,   8'hFB,  1'b1, 16'h0000, "s_0xm5");
    run8(8'd37,  8'd3,   1'b0, 16'd111,  "u_37x3");

    // result holds while inputs wander with start low
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'hA5; sgn8 = 1'b1;
    repeat (4) @(negedge clk);
    check("result_hold", res8, 16'd111);

    // re-pulsed start during busy is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd20; sgn8 = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b0;
    dones = 0; first_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) check("result_hold_busy", res8, 16'd111);
      if (done8) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      start8 = (c == 2 || c == 5);
      if (start8) begin a8 = 8'd3; b8 = 8'd3; sgn8 = 1'b1; end
    end
    start8 = 1'b0;
    check("ignore_start_dones", dones, 1);
    check("ignore_start_latency", first_done, 9);
    check("ignore_start_result", res8, 16'd200);

    // asynchronous reset mid-calculation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100; sgn8 = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_result", res8, 16'h0);
    check("abort_flags", {busy8, done8}, 2'b00);
    check("abort_state", st8, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("abort_no_done", dones, 0);
    run8(8'd7, 8'd6, 1'b0, 16'd42, "post_reset_7x6");

    // back-to-back with start held high
    bb_a[0] = 8'd13;  bb_b[0] = 8'd11; bb_exp[0] = 16'd143;
    bb_a[1] = 8'd200; bb_b[1] = 8'd3;  bb_exp[1] = 16'd600;
    bb_a[2] = 8'd255; bb_b[2] = 8'd1;  bb_exp[2] = 16'd255;
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; a8 = bb_a[0]; b8 = bb_b[0];
    dones = 0; first_done = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (done8) begin
        if (dones < 3) check($sformatf("b2b_result_%0d", dones), res8, bb_exp[dones]);
        if (dones > 0) check($sformatf("b2b_period_%0d", dones), c - first_done, 10);
        first_done = c;
        dones++;
        if (dones < 3) begin
          a8 = bb_a[dones]; b8 = bb_b[dones];
        end else begin
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check("b2b_done_count", dones, 3);

    // 4-bit sweep, both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run4(4'(a), 4'(b), s[0]);

    held = res8;
    check("w8_untouched_by_w4", held, 16'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
